// File: rtl/ex_operand_stage_pkg.sv
// Shared ALU codes, operand-select constants
// and the ID/EX bundle for the RV32I core.
package ex_operand_stage_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic OP1_RS1 = 1'b0;
  localparam logic OP1_PC  = 1'b1;
  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            op1_src;
    logic            op2_src;
    logic [3:0]      alu_func;
  } id_ex_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID fields, MEM/WB forwarding triplets and
// EX-side ALU operand outputs.
interface ex_operand_stage_if;
  import ex_operand_stage_pkg::*;

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [RA_W-1:0] id_rs1_addr;
  logic [RA_W-1:0] id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_write;
  logic            id_op1_src;
  logic            id_op2_src;
  logic [3:0]      id_alu_func;

  logic            mem_fwd_we;
  logic [RA_W-1:0] mem_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data;
  logic            wb_fwd_we;
  logic [RA_W-1:0] wb_fwd_rd;
  logic [XLEN-1:0] wb_fwd_data;

  logic            ex_valid;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [3:0]      ex_alu_func;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;

  modport master (
    output id_valid, id_pc,
    output id_rs1_addr, id_rs2_addr,
    output id_rs1_data, id_rs2_data,
    output id_imm, id_rd, id_reg_write,
    output id_op1_src, id_op2_src,
    output id_alu_func,
    output mem_fwd_we, mem_fwd_rd,
    output mem_fwd_data,
    output wb_fwd_we, wb_fwd_rd,
    output wb_fwd_data,
    input  ex_valid, ex_op1, ex_op2,
    input  ex_alu_func, ex_rd,
    input  ex_reg_write,
    input  ex_store_data, ex_pc
  );

  modport slave (
    input  id_valid, id_pc,
    input  id_rs1_addr, id_rs2_addr,
    input  id_rs1_data, id_rs2_data,
    input  id_imm, id_rd, id_reg_write,
    input  id_op1_src, id_op2_src,
    input  id_alu_func,
    input  mem_fwd_we, mem_fwd_rd,
    input  mem_fwd_data,
    input  wb_fwd_we, wb_fwd_rd,
    input  wb_fwd_data,
    output ex_valid, ex_op1, ex_op2,
    output ex_alu_func, ex_rd,
    output ex_reg_write,
    output ex_store_data, ex_pc
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source forwarding select: MEM beats WB,
// x0 is never forwarded.
module ex_operand_stage_fwd_mux
  import ex_operand_stage_pkg::*;
(
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] stored,
  input  logic            mem_we,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] value,
  output logic            hit
);

  logic nz;
  logic mem_hit;
  logic wb_hit;

  assign nz      = (addr != '0);
  assign mem_hit = nz && mem_we
                && (mem_rd == addr);
  // WB is masked by MEM so the arms stay exclusive
  assign wb_hit  = nz && wb_we
                && (wb_rd == addr)
                && !mem_hit;

  always_comb begin
    value = stored;
    hit   = 1'b0;
    unique case (1'b1)
      mem_hit: begin
        value = mem_data;
        hit   = 1'b1;
      end
      wb_hit: begin
        value = wb_data;
        hit   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with stall/flush and
// forwarded ALU operand selection.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic flush,
  ex_operand_stage_if.slave bus
);

  id_ex_t          q;
  id_ex_t          d;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            hit_rs1;
  logic            hit_rs2;

  always_comb begin
    d           = '0;
    d.valid     = 1'b1;
    d.pc        = bus.id_pc;
    d.rs1_addr  = bus.id_rs1_addr;
    d.rs2_addr  = bus.id_rs2_addr;
    d.rs1_data  = bus.id_rs1_data;
    d.rs2_data  = bus.id_rs2_data;
    d.imm       = bus.id_imm;
    d.rd        = bus.id_rd;
    d.reg_write = bus.id_reg_write;
    d.op1_src   = bus.id_op1_src;
    d.op2_src   = bus.id_op2_src;
    d.alu_func  = bus.id_alu_func;
  end

  // Stalls refresh stored operands so a
  // retiring WB result is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (stall) begin
      if (hit_rs1) q.rs1_data <= fwd_rs1;
      if (hit_rs2) q.rs2_data <= fwd_rs2;
    end else if (bus.id_valid) begin
      q <= d;
    end else begin
      q <= '0;
    end
  end

  ex_operand_stage_fwd_mux u_fwd_rs1 (
    .addr     (q.rs1_addr),
    .stored   (q.rs1_data),
    .mem_we   (bus.mem_fwd_we),
    .mem_rd   (bus.mem_fwd_rd),
    .mem_data (bus.mem_fwd_data),
    .wb_we    (bus.wb_fwd_we),
    .wb_rd    (bus.wb_fwd_rd),
    .wb_data  (bus.wb_fwd_data),
    .value    (fwd_rs1),
    .hit      (hit_rs1)
  );

  ex_operand_stage_fwd_mux u_fwd_rs2 (
    .addr     (q.rs2_addr),
    .stored   (q.rs2_data),
    .mem_we   (bus.mem_fwd_we),
    .mem_rd   (bus.mem_fwd_rd),
    .mem_data (bus.mem_fwd_data),
    .wb_we    (bus.wb_fwd_we),
    .wb_rd    (bus.wb_fwd_rd),
    .wb_data  (bus.wb_fwd_data),
    .value    (fwd_rs2),
    .hit      (hit_rs2)
  );

  assign bus.ex_valid      = q.valid;
  assign bus.ex_op1        = (q.op1_src == OP1_PC)
                           ? q.pc : fwd_rs1;
  assign bus.ex_op2        = (q.op2_src == OP2_IMM)
                           ? q.imm : fwd_rs2;
  assign bus.ex_alu_func   = q.alu_func;
  assign bus.ex_rd         = q.rd;
  assign bus.ex_reg_write  = q.reg_write
                           & q.valid;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_pc         = q.pc;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed checks of load, forwarding, stall
// refresh, flush, operand sources and reset.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;
  int   n_cmp;
  int   n_bad;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(
    input logic        v,
    input logic [31:0] pc,
    input logic [4:0]  a1,
    input logic [4:0]  a2,
    input logic [31:0] d1,
    input logic [31:0] d2,
    input logic [31:0] imm,
    input logic [4:0]  rd,
    input logic        rw,
    input logic        s1,
    input logic        s2,
    input logic [3:0]  fn
  );
    bus.id_valid     = v;
    bus.id_pc        = pc;
    bus.id_rs1_addr  = a1;
    bus.id_rs2_addr  = a2;
    bus.id_rs1_data  = d1;
    bus.id_rs2_data  = d2;
    bus.id_imm       = imm;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_op1_src   = s1;
    bus.id_op2_src   = s2;
    bus.id_alu_func  = fn;
  endtask

  task automatic clear_fwd();
    bus.mem_fwd_we   = 1'b0;
    bus.mem_fwd_rd   = '0;
    bus.mem_fwd_data = '0;
    bus.wb_fwd_we    = 1'b0;
    bus.wb_fwd_rd    = '0;
    bus.wb_fwd_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    clear_fwd();
    drive_id(1'b1, 32'h44, 5'd1, 5'd2,
             32'h9, 32'h8, 32'h3, 5'd6,
             1'b1, 1'b0, 1'b0, ALU_OR);
    tick();
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_valid got %0b exp 0",
               bus.ex_valid);
    end
    n_cmp++;
    if (bus.ex_reg_write !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_rw got %0b exp 0",
               bus.ex_reg_write);
    end
    n_cmp++;
    if (bus.ex_op1 !== 32'h0 ||
        bus.ex_op2 !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_ops got %h %h exp 0",
               bus.ex_op1, bus.ex_op2);
    end
    n_cmp++;
    if (bus.ex_pc !== 32'h0 ||
        bus.ex_rd !== 5'd0 ||
        bus.ex_alu_func !== 4'd0 ||
        bus.ex_store_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_fields pc %h rd %0d fn %0d sd %h exp 0",
               bus.ex_pc, bus.ex_rd,
               bus.ex_alu_func, bus.ex_store_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    drive_id(1'b1, 32'h40, 5'd1, 5'd2,
             32'd5, 32'd7, 32'h0, 5'd4,
             1'b1, 1'b0, 1'b0, ALU_ADD);
    tick();
    n_cmp++;
    if (bus.ex_op1 !== 32'd5 ||
        bus.ex_op2 !== 32'd7) begin
      n_bad++;
      $display("FAIL load_ops got %h %h exp 5 7",
               bus.ex_op1, bus.ex_op2);
    end
    n_cmp++;
    if (bus.ex_valid !== 1'b1 ||
        bus.ex_reg_write !== 1'b1 ||
        bus.ex_rd !== 5'd4) begin
      n_bad++;
      $display("FAIL load_ctl v %0b rw %0b rd %0d exp 1 1 4",
               bus.ex_valid, bus.ex_reg_write,
               bus.ex_rd);
    end
    n_cmp++;
    if (bus.ex_pc !== 32'h40 ||
        bus.ex_alu_func !== ALU_ADD ||
        bus.ex_store_data !== 32'd7) begin
      n_bad++;
      $display("FAIL load_misc pc %h fn %0d sd %h exp 40 0 7",
               bus.ex_pc, bus.ex_alu_func,
               bus.ex_store_data);
    end
  endtask

  task automatic test_priority();
    drive_id(1'b1, 32'h50, 5'd3, 5'd9,
             32'h11, 32'h99, 32'h0, 5'd5,
             1'b1, 1'b0, 1'b0, ALU_SUB);
    tick();
    bus.mem_fwd_we   = 1'b1;
    bus.mem_fwd_rd   = 5'd3;
    bus.mem_fwd_data = 32'hAA;
    bus.wb_fwd_we    = 1'b1;
    bus.wb_fwd_rd    = 5'd3;
    bus.wb_fwd_data  = 32'hBB;
    #1;
    n_cmp++;
    if (bus.ex_op1 !== 32'hAA) begin
      n_bad++;
      $display("FAIL prio_mem got %h exp aa",
               bus.ex_op1);
    end
    n_cmp++;
    if (bus.ex_op2 !== 32'h99) begin
      n_bad++;
      $display("FAIL prio_nohit got %h exp 99",
               bus.ex_op2);
    end
    bus.mem_fwd_we = 1'b0;
    #1;
    n_cmp++;
    if (bus.ex_op1 !== 32'hBB) begin
      n_bad++;
      $display("FAIL prio_wb got %h exp bb",
               bus.ex_op1);
    end
    clear_fwd();
    drive_id(1'b1, 32'h54, 5'd0, 5'd0,
             32'h22, 32'h33, 32'h0, 5'd5,
             1'b1, 1'b0, 1'b0, ALU_ADD);
    tick();
    bus.mem_fwd_we   = 1'b1;
    bus.mem_fwd_rd   = 5'd0;
    bus.mem_fwd_data = 32'hAA;
    bus.wb_fwd_we    = 1'b1;
    bus.wb_fwd_rd    = 5'd0;
    bus.wb_fwd_data  = 32'hBB;
    #1;
    n_cmp++;
    if (bus.ex_op1 !== 32'h22 ||
        bus.ex_op2 !== 32'h33) begin
      n_bad++;
      $display("FAIL prio_x0 got %h %h exp 22 33",
               bus.ex_op1, bus.ex_op2);
    end
    clear_fwd();
  endtask

  task automatic test_stall_refresh();
    drive_id(1'b1, 32'h60, 5'd1, 5'd6,
             32'h1, 32'h9, 32'h0, 5'd7,
             1'b1, 1'b0, 1'b0, ALU_XOR);
    tick();
    stall = 1'b1;
    drive_id(1'b1, 32'h64, 5'd2, 5'd8,
             32'h5555, 32'h6666, 32'h0, 5'd9,
             1'b0, 1'b0, 1'b0, ALU_AND);
    bus.wb_fwd_we   = 1'b1;
    bus.wb_fwd_rd   = 5'd6;
    bus.wb_fwd_data = 32'h1234;
    tick();
    bus.wb_fwd_we = 1'b0;
    #1;
    n_cmp++;
    if (bus.ex_store_data !== 32'h1234) begin
      n_bad++;
      $display("FAIL stall_c1 got %h exp 1234",
               bus.ex_store_data);
    end
    tick();
    n_cmp++;
    if (bus.ex_store_data !== 32'h1234 ||
        bus.ex_op2 !== 32'h1234) begin
      n_bad++;
      $display("FAIL stall_c2 got %h %h exp 1234",
               bus.ex_store_data, bus.ex_op2);
    end
    n_cmp++;
    if (bus.ex_pc !== 32'h60 ||
        bus.ex_rd !== 5'd7 ||
        bus.ex_alu_func !== ALU_XOR ||
        bus.ex_op1 !== 32'h1) begin
      n_bad++;
      $display("FAIL stall_hold pc %h rd %0d fn %0d op1 %h exp 60 7 5 1",
               bus.ex_pc, bus.ex_rd,
               bus.ex_alu_func, bus.ex_op1);
    end
    stall = 1'b0;
    clear_fwd();
  endtask

  task automatic test_flush_stall();
    drive_id(1'b1, 32'h70, 5'd1, 5'd2,
             32'h3, 32'h4, 32'h0, 5'd12,
             1'b1, 1'b0, 1'b0, ALU_SLT);
    tick();
    stall = 1'b1;
    flush = 1'b1;
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b0 ||
        bus.ex_reg_write !== 1'b0 ||
        bus.ex_rd !== 5'd0) begin
      n_bad++;
      $display("FAIL flush_ctl v %0b rw %0b rd %0d exp 0",
               bus.ex_valid, bus.ex_reg_write,
               bus.ex_rd);
    end
    n_cmp++;
    if (bus.ex_op1 !== 32'h0 ||
        bus.ex_pc !== 32'h0 ||
        bus.ex_alu_func !== 4'd0) begin
      n_bad++;
      $display("FAIL flush_data op1 %h pc %h fn %0d exp 0",
               bus.ex_op1, bus.ex_pc,
               bus.ex_alu_func);
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_sources();
    drive_id(1'b1, 32'h100, 5'd1, 5'd7,
             32'h11, 32'h77, 32'hFFFFF800,
             5'd3, 1'b1, 1'b1, 1'b1, ALU_ADD);
    tick();
    n_cmp++;
    if (bus.ex_op1 !== 32'h100 ||
        bus.ex_op2 !== 32'hFFFFF800) begin
      n_bad++;
      $display("FAIL src_ops got %h %h exp 100 fffff800",
               bus.ex_op1, bus.ex_op2);
    end
    n_cmp++;
    if (bus.ex_store_data !== 32'h77) begin
      n_bad++;
      $display("FAIL src_sd got %h exp 77",
               bus.ex_store_data);
    end
    bus.mem_fwd_we   = 1'b1;
    bus.mem_fwd_rd   = 5'd7;
    bus.mem_fwd_data = 32'hCAFE;
    #1;
    n_cmp++;
    if (bus.ex_store_data !== 32'hCAFE ||
        bus.ex_op2 !== 32'hFFFFF800) begin
      n_bad++;
      $display("FAIL src_fwd sd %h op2 %h exp cafe fffff800",
               bus.ex_store_data, bus.ex_op2);
    end
    clear_fwd();
  endtask

  task automatic test_bubble();
    drive_id(1'b0, 32'h200, 5'd1, 5'd2,
             32'h5, 32'h6, 32'h7, 5'd8,
             1'b1, 1'b0, 1'b0, ALU_SRA);
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b0 ||
        bus.ex_reg_write !== 1'b0 ||
        bus.ex_pc !== 32'h0 ||
        bus.ex_op1 !== 32'h0) begin
      n_bad++;
      $display("FAIL bubble v %0b rw %0b pc %h op1 %h exp 0",
               bus.ex_valid, bus.ex_reg_write,
               bus.ex_pc, bus.ex_op1);
    end
  endtask

  task automatic test_async_reset();
    drive_id(1'b1, 32'h300, 5'd1, 5'd2,
             32'hA, 32'hB, 32'h0, 5'd10,
             1'b1, 1'b0, 1'b0, ALU_SLL);
    tick();
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.ex_valid !== 1'b0 ||
        bus.ex_op1 !== 32'h0 ||
        bus.ex_pc !== 32'h0 ||
        bus.ex_rd !== 5'd0) begin
      n_bad++;
      $display("FAIL async_rst v %0b op1 %h pc %h rd %0d exp 0",
               bus.ex_valid, bus.ex_op1,
               bus.ex_pc, bus.ex_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    drive_id(1'b1, 32'h304, 5'd1, 5'd2,
             32'hC, 32'hD, 32'h0, 5'd11,
             1'b1, 1'b0, 1'b0, ALU_OR);
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b1 ||
        bus.ex_op1 !== 32'hC ||
        bus.ex_pc !== 32'h304) begin
      n_bad++;
      $display("FAIL post_rst v %0b op1 %h pc %h exp 1 c 304",
               bus.ex_valid, bus.ex_op1,
               bus.ex_pc);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_load();
    test_priority();
    test_stall_refresh();
    test_flush_stall();
    test_sources();
    test_bubble();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
